// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clock-enable generator.
// Turbo encodings give the CPU speed-up as a power of two over the base divisor.
package clkdiv_pkg;

    localparam int TURBO_W          = 2;
    localparam int DEFAULT_NUM_TAPS = 3;
    localparam int DEFAULT_CPU_LOG2 = 3;

    typedef enum logic [TURBO_W-1:0] {
        T_1X = 2'd0,
        T_2X = 2'd1,
        T_4X = 2'd2,
        T_8X = 2'd3
    } turbo_e;

    // Mask of the n low bits; a zero-width mask makes any phase compare true.
    function automatic logic [31:0] low_mask(input int n);
        if (n <= 0) begin
            return 32'd0;
        end
        if (n >= 32) begin
            return '1;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Control and enable bundle between the clock-enable generator and its users.
// The slave modport is the generator; master is whoever steers turbo/hold/resync.
interface clkdiv_if #(
    parameter int NUM_TAPS = clkdiv_pkg::DEFAULT_NUM_TAPS
);
    import clkdiv_pkg::*;

    logic [TURBO_W-1:0]  turbo_sel;
    logic                cpu_hold;
    logic                resync;
    logic [NUM_TAPS-1:0] ce_tap;
    logic                ce_cpu;
    logic [TURBO_W-1:0]  turbo_cur;
    logic [NUM_TAPS-1:0] clk_div;

    modport master (
        output turbo_sel,
        output cpu_hold,
        output resync,
        input  ce_tap,
        input  ce_cpu,
        input  turbo_cur,
        input  clk_div
    );

    modport slave (
        input  turbo_sel,
        input  cpu_hold,
        input  resync,
        output ce_tap,
        output ce_cpu,
        output turbo_cur,
        output clk_div
    );

endinterface

// File: rtl/clkdiv_enables.sv
// Free-running counter producing fixed power-of-two enables plus a turbo-selectable CPU enable.
// Define CLKDIV_CLKOUT_EN to also register 50% divided square waves on clk_div.
module clkdiv_enables
    import clkdiv_pkg::*;
#(
    parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
    parameter int CPU_LOG2 = DEFAULT_CPU_LOG2,
    parameter int CNT_W    = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    clkdiv_if.slave bus
);

    generate
        if (CNT_W < NUM_TAPS || CNT_W < CPU_LOG2) begin : g_bad_cfg
            $error("clkdiv_enables: CNT_W too narrow for NUM_TAPS/CPU_LOG2");
        end
    endgenerate

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [31:0]         cnt_ext;
    logic [NUM_TAPS-1:0] ce_tap_q;
    logic [NUM_TAPS-1:0] ce_tap_nx;
    logic                ce_cpu_q;
    logic                ce_cpu_nx;
    turbo_e              turbo_cur_q;
    turbo_e              turbo_cur_nx;
    logic                boundary;
    int                  cpu_div;

    // The live turbo_sel is the most recent request, so it is what a boundary adopts.
    always_comb begin
        cnt_nx       = bus.resync ? '0 : cnt + CNT_W'(1);
        cnt_ext      = 32'(cnt_nx);
        boundary     = (cnt_ext & low_mask(CPU_LOG2)) == 32'd0;
        turbo_cur_nx = boundary ? turbo_e'(bus.turbo_sel) : turbo_cur_q;
        cpu_div      = (int'(turbo_cur_nx) >= CPU_LOG2) ? 0 : CPU_LOG2 - int'(turbo_cur_nx);
        ce_cpu_nx    = ((cnt_ext & low_mask(cpu_div)) == 32'd0) && !bus.cpu_hold;
        ce_tap_nx    = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            ce_tap_nx[k] = (cnt_ext & low_mask(k + 1)) == 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            ce_tap_q    <= '0;
            ce_cpu_q    <= 1'b0;
            turbo_cur_q <= T_1X;
        end else begin
            cnt         <= cnt_nx;
            ce_tap_q    <= ce_tap_nx;
            ce_cpu_q    <= ce_cpu_nx;
            turbo_cur_q <= turbo_cur_nx;
        end
    end

    assign bus.ce_tap    = ce_tap_q;
    assign bus.ce_cpu    = ce_cpu_q;
    assign bus.turbo_cur = turbo_cur_q;

`ifdef CLKDIV_CLKOUT_EN
    logic [NUM_TAPS-1:0] clk_div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_q <= '0;
        end else begin
            clk_div_q <= cnt_nx[NUM_TAPS-1:0];
        end
    end

    assign bus.clk_div = clk_div_q;
`else
    assign bus.clk_div = '0;
`endif

endmodule

// File: tb/tb_clkdiv_enables.sv
// Scoreboard bench for clkdiv_enables: a modulo-arithmetic model predicts every output per edge.
// Honours CLKDIV_CLKOUT_EN the same way as the design when predicting clk_div.
module tb_clkdiv_enables;
    import clkdiv_pkg::*;

    localparam int NUM_TAPS = 3;
    localparam int CPU_LOG2 = 3;
    localparam int CNT_W    = 4;
    localparam int CNT_MOD  = 1 << CNT_W;

    typedef struct packed {
        logic [NUM_TAPS-1:0] tap;
        logic                cpu;
        logic [TURBO_W-1:0]  turbo;
        logic [NUM_TAPS-1:0] div;
    } snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clkdiv_if #(.NUM_TAPS(NUM_TAPS)) bus();

    clkdiv_enables #(
        .NUM_TAPS(NUM_TAPS),
        .CPU_LOG2(CPU_LOG2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    m_cnt    = 0;
    int    m_turbo  = 0;
    int    edge_no  = 0;
    snap_t sb[$];

    function automatic snap_t observe();
        return {bus.ce_tap, bus.ce_cpu, bus.turbo_cur, bus.clk_div};
    endfunction

    // Predict the coming edge from the inputs now applied, push it, then step past the edge.
    task automatic advance();
        snap_t e;
        int    nx;
        int    d;
        nx = bus.resync ? 0 : (m_cnt + 1) % CNT_MOD;
        if (nx % (1 << CPU_LOG2) == 0) begin
            m_turbo = int'(bus.turbo_sel);
        end
        d = (m_turbo >= CPU_LOG2) ? 0 : CPU_LOG2 - m_turbo;
        for (int k = 0; k < NUM_TAPS; k++) begin
            e.tap[k] = (nx % (2 << k)) == 0;
        end
        e.cpu   = ((nx % (1 << d)) == 0) && !bus.cpu_hold;
        e.turbo = TURBO_W'(m_turbo);
`ifdef CLKDIV_CLKOUT_EN
        for (int k = 0; k < NUM_TAPS; k++) begin
            e.div[k] = ((nx >> k) & 1) == 1;
        end
`else
        e.div = '0;
`endif
        m_cnt = nx;
        sb.push_back(e);
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic test_reset();
        snap_t exp;
        snap_t obs;
        int    first_edge[NUM_TAPS];
        bus.turbo_sel = 2'd0;
        bus.cpu_hold  = 1'b0;
        bus.resync    = 1'b0;
        rst_n         = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (observe() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=0", observe());
        end
        rst_n   = 1'b1;
        m_cnt   = 0;
        m_turbo = 0;
        edge_no = 0;
        for (int k = 0; k < NUM_TAPS; k++) first_edge[k] = -1;
        for (int i = 0; i < 8; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL reset_release edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (obs.tap[k] === 1'b1 && first_edge[k] < 0) first_edge[k] = edge_no;
            end
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
            checks++;
            if (first_edge[k] != (2 << k)) begin
                failures++;
                $display("[TB] FAIL first_tap%0d got edge %0d want edge %0d", k, first_edge[k], 2 << k);
            end
        end
    endtask

    task automatic test_periods();
        snap_t exp;
        snap_t obs;
        snap_t prev;
        int    tap_cnt[NUM_TAPS];
        int    cpu_cnt;
        int    wide;
        prev    = '0;
        cpu_cnt = 0;
        wide    = 0;
        for (int k = 0; k < NUM_TAPS; k++) tap_cnt[k] = 0;
        for (int i = 0; i < 64; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL periods_cycle edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.cpu === 1'b1) cpu_cnt++;
            if (obs.cpu === 1'b1 && prev.cpu === 1'b1) wide++;
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (obs.tap[k] === 1'b1) tap_cnt[k]++;
                if (obs.tap[k] === 1'b1 && prev.tap[k] === 1'b1) wide++;
            end
            prev = obs;
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
            checks++;
            if (tap_cnt[k] != (64 >> (k + 1))) begin
                failures++;
                $display("[TB] FAIL period_tap%0d got %0d pulses want %0d", k, tap_cnt[k], 64 >> (k + 1));
            end
        end
        checks++;
        if (cpu_cnt != 8) begin
            failures++;
            $display("[TB] FAIL period_cpu got %0d pulses want 8", cpu_cnt);
        end
        checks++;
        if (wide != 0) begin
            failures++;
            $display("[TB] FAIL pulse_width got %0d multi-cycle pulses want 0", wide);
        end
    endtask

    task automatic test_turbo();
        snap_t exp;
        snap_t obs;
        int    guard;
        int    last_cpu;
        int    min_gap;
        int    cpu_cnt;
        guard = 0;
        while (m_cnt != 3 && guard < 32) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL turbo_align edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            guard++;
        end
        checks++;
        if (m_cnt != 3) begin
            failures++;
            $display("[TB] FAIL turbo_align_timeout got cnt %0d want 3", m_cnt);
        end
        bus.turbo_sel = 2'd2;
        last_cpu = edge_no - 3;
        min_gap  = 1000;
        cpu_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL turbo_cycle edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (i < 4) begin
                checks++;
                if (obs.turbo !== 2'd0) begin
                    failures++;
                    $display("[TB] FAIL turbo_early edge=%0d got %0d want 0", edge_no, obs.turbo);
                end
            end
            if (i == 4) begin
                checks++;
                if (obs.turbo !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL turbo_switch got %0d want 2", obs.turbo);
                end
            end
            if (obs.cpu === 1'b1) begin
                if (edge_no - last_cpu < min_gap) min_gap = edge_no - last_cpu;
                last_cpu = edge_no;
                if (i >= 4) cpu_cnt++;
            end
        end
        checks++;
        if (min_gap < 2) begin
            failures++;
            $display("[TB] FAIL turbo_min_gap got %0d want >=2", min_gap);
        end
        checks++;
        if (cpu_cnt != 6) begin
            failures++;
            $display("[TB] FAIL turbo_rate got %0d pulses in 12 cycles want 6", cpu_cnt);
        end
        // Two requests before one boundary: only the later one takes effect.
        bus.turbo_sel = 2'd1;
        advance();
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL turbo_req1 edge=%0d got=%h want=%h", edge_no, obs, exp);
        end
        bus.turbo_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL turbo_req3 edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
        end
        checks++;
        if (obs.turbo !== 2'd3) begin
            failures++;
            $display("[TB] FAIL turbo_last_wins got %0d want 3", obs.turbo);
        end
        cpu_cnt = (obs.cpu === 1'b1) ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL turbo_sat_cycle edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.cpu === 1'b1) cpu_cnt++;
        end
        checks++;
        if (cpu_cnt != 8) begin
            failures++;
            $display("[TB] FAIL turbo_saturate got %0d pulses in 8 cycles want 8", cpu_cnt);
        end
        bus.turbo_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL turbo_restore edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_hold();
        snap_t exp;
        snap_t obs;
        int    guard;
        int    cpu_cnt;
        int    tap2_cnt;
        int    first_cnt;
        guard = 0;
        while (m_cnt != 6 && guard < 32) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL hold_align edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            guard++;
        end
        bus.cpu_hold = 1'b1;
        cpu_cnt  = 0;
        tap2_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL hold_cycle edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.cpu === 1'b1) cpu_cnt++;
            if (obs.tap[2] === 1'b1) tap2_cnt++;
        end
        bus.cpu_hold = 1'b0;
        checks++;
        if (cpu_cnt != 0) begin
            failures++;
            $display("[TB] FAIL hold_suppress got %0d pulses want 0", cpu_cnt);
        end
        checks++;
        if (tap2_cnt != 1) begin
            failures++;
            $display("[TB] FAIL hold_tap_unaffected got %0d tap2 pulses want 1", tap2_cnt);
        end
        first_cnt = -1;
        for (int i = 0; i < 8; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL hold_after edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.cpu === 1'b1 && first_cnt < 0) first_cnt = i;
        end
        checks++;
        if (first_cnt != 4) begin
            failures++;
            $display("[TB] FAIL hold_rephase got pulse at offset %0d want 4", first_cnt);
        end
    endtask

    task automatic test_resync();
        snap_t exp;
        snap_t obs;
        int    guard;
        int    tap2_at;
        guard = 0;
        while (m_cnt != 4 && guard < 32) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL resync_align edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            guard++;
        end
        bus.turbo_sel = 2'd1;
        advance();
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs.turbo !== 2'd0 || obs !== exp) begin
            failures++;
            $display("[TB] FAIL resync_pending edge=%0d got=%h want=%h", edge_no, obs, exp);
        end
        bus.resync = 1'b1;
        advance();
        bus.resync = 1'b0;
        exp = sb.pop_front();
        obs = observe();
        checks++;
        if (obs.tap !== 3'b111 || obs.cpu !== 1'b1 || obs.turbo !== 2'd1) begin
            failures++;
            $display("[TB] FAIL resync_edge got tap=%b cpu=%b turbo=%0d want tap=111 cpu=1 turbo=1",
                     obs.tap, obs.cpu, obs.turbo);
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL resync_model got=%h want=%h", obs, exp);
        end
        tap2_at = -1;
        for (int i = 1; i <= 8; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL resync_after edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.tap[2] === 1'b1 && tap2_at < 0) tap2_at = i;
        end
        checks++;
        if (tap2_at != 8) begin
            failures++;
            $display("[TB] FAIL resync_rephase got tap2 at offset %0d want 8", tap2_at);
        end
        bus.resync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs.tap !== 3'b111 || obs.cpu !== 1'b1 || obs !== exp) begin
                failures++;
                $display("[TB] FAIL resync_held edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
        end
        bus.resync    = 1'b0;
        bus.turbo_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL resync_restore edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        snap_t exp;
        snap_t obs;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h want=0", observe());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_cnt   = 0;
        m_turbo = 0;
        for (int i = 0; i < 4; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL mid_reset_release edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_clkdiv();
        snap_t exp;
        snap_t obs;
        logic  prev1;
        int    high_cnt;
        int    toggles;
        int    nonzero;
        prev1    = bus.clk_div[1];
        high_cnt = 0;
        toggles  = 0;
        nonzero  = 0;
        for (int i = 0; i < 32; i++) begin
            advance();
            exp = sb.pop_front();
            obs = observe();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL clkdiv_cycle edge=%0d got=%h want=%h", edge_no, obs, exp);
            end
            if (obs.div[1] === 1'b1) high_cnt++;
            if (obs.div[1] !== prev1) toggles++;
            if (obs.div !== '0) nonzero++;
            prev1 = obs.div[1];
        end
`ifdef CLKDIV_CLKOUT_EN
        checks++;
        if (high_cnt != 16 || toggles != 16) begin
            failures++;
            $display("[TB] FAIL clkdiv_square got high=%0d toggles=%0d want high=16 toggles=16",
                     high_cnt, toggles);
        end
`else
        checks++;
        if (nonzero != 0) begin
            failures++;
            $display("[TB] FAIL clkdiv_tied got %0d nonzero cycles want 0", nonzero);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.turbo_sel = 2'd0;
        bus.cpu_hold  = 1'b0;
        bus.resync    = 1'b0;
        test_reset();
        test_periods();
        test_turbo();
        test_hold();
        test_resync();
        test_mid_reset();
        test_clkdiv();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
